dac_transmitter: RTL and testbench



---
 rtl/dac_pkg.sv | 13 +
 rtl/dac_transmitter_sample_fifo.sv | 48 ++++
 rtl/dac_transmitter.sv | 104 ++++++++++
 tb/tb_dac_transmitter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// dac_pkg: shared state type and constants for the DAC transmit path.
//   state_t       : transmitter FSM states
//   DATA_W        : default DAC bus width
//   CLK_PSRAM_MHZ : system clock frequency, used to derive the divider
package dac_pkg;
    typedef enum logic [1:0] {IDLE, PRIME, RUN, STOP} state_t;
    localparam int DATA_W = 12;
    localparam int CLK_PSRAM_MHZ = 84;
    // Half-period divider giving the requested DAC sample rate in kHz.
    function automatic int clk_div_for(input int rate_khz);
        return (CLK_PSRAM_MHZ * 1000) / (2 * rate_khz);
    endfunction
endpackage

// File: rtl/dac_transmitter_sample_fifo.sv
// sample_fifo: synchronous FIFO buffering DAC samples.
//   clk_PSRAM, rst : clock, asynchronous active-high reset
//   push, wdata    : write request and data (ignored when full)
//   pop, rdata     : read request (ignored when empty) and head of queue
//   full, empty    : occupancy flags
//   count          : number of stored entries
module sample_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk_PSRAM,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_PSRAM) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_PSRAM or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/dac_transmitter.sv
// dac_transmitter: streams buffered samples onto a parallel DAC bus with a divided DAC clock.
//   clk_PSRAM, rst    : system clock, asynchronous active-high reset
//   dac_enable        : level request to stream
//   s_data/valid/ready: upstream sample handshake into the internal FIFO
//   dac_clk, dac_data : DAC clock and registered data bus (DAC latches on rising edge)
//   running           : high while streaming
//   underflow         : sticky, FIFO was empty at a required sample update
module dac_transmitter
    import dac_pkg::*;
#(
    parameter int DATA_W      = dac_pkg::DATA_W,
    parameter int CLK_DIV     = clk_div_for(1000),
    parameter int FIFO_DEPTH  = 4,
    parameter int PRIME_LEVEL = 2
) (
    input  logic              clk_PSRAM,
    input  logic              rst,
    input  logic              dac_enable,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              dac_clk,
    output logic [DATA_W-1:0] dac_data,
    output logic              running,
    output logic              underflow
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [DATA_W-1:0] head;
    logic [CNT_W-1:0]  count;
    logic              full, empty, pop, tick, fall, primed;

    assign tick    = div == DIV_W'(CLK_DIV - 1);
    // Samples change on the falling toggle, half a DAC period before the latching edge.
    assign fall    = tick && dac_clk;
    assign primed  = count >= CNT_W'(PRIME_LEVEL);
    assign s_ready = !full;
    assign pop     = (state == PRIME && dac_enable && primed) || (state == RUN && fall && !empty);

    sample_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_PSRAM (clk_PSRAM),
        .rst       (rst),
        .push      (s_valid),
        .wdata     (s_data),
        .pop       (pop),
        .rdata     (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk_PSRAM or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div       <= '0;
            dac_clk   <= 1'b0;
            dac_data  <= '0;
            running   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div     <= '0;
                    dac_clk <= 1'b0;
                    if (dac_enable) begin
                        state     <= PRIME;
                        underflow <= 1'b0;
                    end
                end
                PRIME: begin
                    if (!dac_enable) state <= IDLE;
                    else if (primed) begin
                        state    <= RUN;
                        running  <= 1'b1;
                        dac_data <= head;
                        div      <= '0;
                        dac_clk  <= 1'b0;
                    end
                end
                RUN: begin
                    div <= tick ? '0 : div + 1'b1;
                    if (tick) dac_clk <= !dac_clk;
                    if (fall) begin
                        if (!empty) dac_data <= head;
                        else underflow <= 1'b1;
                    end
                    if (!dac_enable) begin
                        state   <= STOP;
                        running <= 1'b0;
                    end
                end
                STOP: begin
                    // Finish the current DAC period so no runt pulse reaches the DAC.
                    div <= tick ? '0 : div + 1'b1;
                    if (tick) dac_clk <= !dac_clk;
                    if (fall) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dac_transmitter.sv
// tb_dac_transmitter: directed and randomized checks of dac_transmitter against a timing-level model.
module tb_dac_transmitter;
    localparam int CD = 2;
    localparam int FD = 4;
    localparam int PL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dac_enable = 1'b0;
    logic [11:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready, dac_clk, running, underflow;
    logic [11:0] dac_data;

    int checks = 0;
    int failures = 0;

    dac_transmitter #(.DATA_W(12), .CLK_DIV(CD), .FIFO_DEPTH(FD), .PRIME_LEVEL(PL)) dut (
        .clk_PSRAM  (clk),
        .rst        (rst),
        .dac_enable (dac_enable),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .dac_clk    (dac_clk),
        .dac_data   (dac_data),
        .running    (running),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 waiting for samples, 2 streaming, 3 finishing the period.
    // k counts cycles since streaming began; the DAC clock is a pure function of k.
    logic [11:0] q[$];
    int          md = 0;
    int          k = 0;
    logic [11:0] m_data = '0;
    logic        m_uf = 1'b0;
    logic        m_push;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            md = 0;
            k = 0;
            m_data = '0;
            m_uf = 1'b0;
        end else begin
            m_push = s_valid && (q.size() < FD);
            if (md == 0) begin
                if (dac_enable) begin
                    md = 1;
                    m_uf = 1'b0;
                end
            end else if (md == 1) begin
                if (!dac_enable) md = 0;
                else if (q.size() >= PL) begin
                    md = 2;
                    k = 0;
                    m_data = q.pop_front();
                end
            end else begin
                k++;
                if (k % (2 * CD) == 0) begin
                    if (md == 3) md = 0;
                    else if (q.size() > 0) m_data = q.pop_front();
                    else m_uf = 1'b1;
                end
                if (md == 2 && !dac_enable) md = 3;
            end
            if (m_push) q.push_back(s_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("model dac_clk", 32'(dac_clk), (md >= 2) ? 32'((k / CD) % 2) : 32'd0);
            chk("model dac_data", 32'(dac_data), 32'(m_data));
            chk("model running", 32'(running), 32'(md == 2));
            chk("model underflow", 32'(underflow), 32'(m_uf));
            chk("model s_ready", 32'(s_ready), 32'(q.size() < FD));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push1(input logic [11:0] d);
        s_valid = 1'b1;
        s_data = d;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("reset dac_clk", 32'(dac_clk), 0);
        chk("reset dac_data", 32'(dac_data), 0);
        chk("reset running", 32'(running), 0);
        chk("reset underflow", 32'(underflow), 0);
        chk("reset s_ready", 32'(s_ready), 1);
        rst = 1'b0;

        // Basic stream from a preloaded FIFO.
        push1(12'h123);
        push1(12'h456);
        push1(12'h789);
        dac_enable = 1'b1;
        tick();
        chk("prime running", 32'(running), 0);
        tick();
        chk("first sample", 32'(dac_data), 32'h123);
        chk("run running", 32'(running), 1);
        chk("run clk low", 32'(dac_clk), 0);
        tick(2);
        chk("first rise", 32'(dac_clk), 1);
        tick(2);
        chk("first fall clk", 32'(dac_clk), 0);
        chk("second sample", 32'(dac_data), 32'h456);
        tick(4);
        chk("third sample", 32'(dac_data), 32'h789);
        tick(4);
        chk("underflow hold", 32'(dac_data), 32'h789);
        chk("underflow set", 32'(underflow), 1);
        push1(12'habc);
        tick(3);
        chk("resume sample", 32'(dac_data), 32'habc);
        chk("underflow sticky", 32'(underflow), 1);

        // Clean stop from the low phase.
        dac_enable = 1'b0;
        tick();
        chk("stop running", 32'(running), 0);
        chk("stop clk low", 32'(dac_clk), 0);
        tick();
        chk("stop high phase", 32'(dac_clk), 1);
        tick(2);
        chk("stop final clk", 32'(dac_clk), 0);
        chk("stop data held", 32'(dac_data), 32'habc);
        tick(2);
        chk("idle clk", 32'(dac_clk), 0);
        chk("idle underflow kept", 32'(underflow), 1);

        // Prime gate.
        push1(12'h111);
        dac_enable = 1'b1;
        tick();
        chk("underflow cleared", 32'(underflow), 0);
        tick(3);
        chk("gate running", 32'(running), 0);
        chk("gate clk", 32'(dac_clk), 0);
        push1(12'h222);
        tick();
        chk("gate release", 32'(running), 1);
        chk("gate sample", 32'(dac_data), 32'h111);
        tick(5);
        chk("gate second", 32'(dac_data), 32'h222);

        // Asynchronous reset mid-stream.
        #2 rst = 1'b1;
        #1;
        chk("async dac_clk", 32'(dac_clk), 0);
        chk("async dac_data", 32'(dac_data), 0);
        chk("async running", 32'(running), 0);
        chk("async underflow", 32'(underflow), 0);
        chk("async s_ready", 32'(s_ready), 1);
        dac_enable = 1'b0;
        tick();
        rst = 1'b0;

        // Backpressure.
        push1(12'h401);
        push1(12'h402);
        push1(12'h403);
        push1(12'h404);
        chk("full s_ready", 32'(s_ready), 0);
        s_valid = 1'b1;
        s_data = 12'h555;
        tick();
        chk("full held", 32'(s_ready), 0);
        dac_enable = 1'b1;
        tick(2);
        chk("bp first pop", 32'(dac_data), 32'h401);
        chk("bp ready", 32'(s_ready), 1);
        s_valid = 1'b0;
        tick(16);
        chk("bp fifth rejected", 32'(dac_data), 32'h404);
        chk("bp underflow", 32'(underflow), 1);
        dac_enable = 1'b0;
        tick(10);

        // Randomized traffic with varying upstream rates.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) dac_enable = !dac_enable;
            s_valid = $urandom_range(0, 99) < ((i / 500) % 4) * 25 + 10;
            s_data = 12'($urandom);
            if (i == 2100) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
